// File: rtl/periph_bus_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter: address map,
// FSM state encoding and master indices.
package periph_bus_pkg;

   localparam logic [31:0] ADDR_DIN    = 32'd0;
   localparam logic [31:0] ADDR_DOUT   = 32'd4;
   localparam logic [31:0] ADDR_TIMER0 = 32'd8;
   localparam logic [31:0] ADDR_7SEG   = 32'd12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Callers zero-extend their address, so this holds for any AW up to 32.
   function automatic logic addr_valid(input logic [31:0] addr);
      return (addr == ADDR_DIN)    || (addr == ADDR_DOUT) ||
             (addr == ADDR_TIMER0) || (addr == ADDR_7SEG);
   endfunction

endpackage

// File: rtl/periph_rr_pick.sv
// Two-way winner selection: round-robin against last_grant, or fixed
// priority with m0 winning when RR_EN is 0.
module periph_rr_pick
   import periph_bus_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       any_req,
   output logic       winner
);

   always_comb begin
      any_req = |req;
      winner  = M0;
      case (req)
         2'b10:   winner = M1;
         2'b11:   winner = (RR_EN != 0) ? ~last_grant : M0;
         default: winner = M0;
      endcase
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the registered peripheral bus between the CPU data port (m0) and the
// debug/loader master (m1) using an IDLE -> ACCESS -> RESP sequence.
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter int AW    = 4,
   parameter int DW    = 32,
   parameter int RR_EN = 1
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ready,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ready,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,

   output logic [AW-1:0] A,
   output logic [DW-1:0] WD,
   output logic          WE,
   input  logic [DW-1:0] RD,
   output logic          busy
);

   state_t        state;
   logic          cur;
   logic          last_grant;
   logic          valid_q;
   logic          we_q;

   logic          any_req;
   logic          winner;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_valid;
   logic [DW-1:0] resp_rdata;

   periph_rr_pick #(
      .RR_EN (RR_EN)
   ) u_pick (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .any_req    (any_req),
      .winner     (winner)
   );

   // Request fields of whichever master the picker chose this cycle.
   always_comb begin
      sel_we    = (winner == M1) ? m1_we    : m0_we;
      sel_addr  = (winner == M1) ? m1_addr  : m0_addr;
      sel_wdata = (winner == M1) ? m1_wdata : m0_wdata;
      sel_valid = addr_valid(32'(sel_addr));
   end

   // Only a mapped read returns peripheral data; writes and unmapped hits give 0.
   always_comb begin
      resp_rdata = (valid_q && !we_q) ? RD : '0;
   end

   assign busy = (state != IDLE);

   // Single FSM register block: bus outputs and per-master responses are all
   // registered here so the granted master only ever sees clean pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur        <= M0;
         last_grant <= M1;
         valid_q    <= 1'b0;
         we_q       <= 1'b0;
         A          <= '0;
         WD         <= '0;
         WE         <= 1'b0;
         m0_ready   <= 1'b0;
         m0_rdata   <= '0;
         m0_err     <= 1'b0;
         m1_ready   <= 1'b0;
         m1_rdata   <= '0;
         m1_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  cur        <= winner;
                  last_grant <= winner;
                  A          <= sel_addr;
                  WD         <= sel_wdata;
                  valid_q    <= sel_valid;
                  we_q       <= sel_we;
                  WE         <= sel_we & sel_valid;
                  state      <= ACCESS;
               end
            end

            ACCESS: begin
               WE <= 1'b0;
               if (cur == M1) begin
                  m1_rdata <= resp_rdata;
                  m1_err   <= ~valid_q;
                  m1_ready <= 1'b1;
               end else begin
                  m0_rdata <= resp_rdata;
                  m0_err   <= ~valid_q;
                  m0_ready <= 1'b1;
               end
               state <= RESP;
            end

            RESP: begin
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               WE       <= 1'b0;
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral bus (A[3:0], WD, WE, RD) between two masters.
- m0 is the CPU data port; m1 is the debug/loader master.
- Each master has a req/ready handshake. The arbiter runs a 3-state FSM and uses round-robin (or fixed-priority) selection.
- Bus outputs are registered. Accesses to unmapped addresses are flagged with err and never reach the peripherals.

Parameters:
- AW, 4, peripheral address width.
- DW, 32, data width.
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority with m0 winning.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  m0 transaction request; held high until m0_ready.
- m0_we  input  1  m0 write (1) or read (0); stable while m0_req is high.
- m0_addr  input  AW  m0 address; stable while m0_req is high.
- m0_wdata  input  DW  m0 write data; stable while m0_req is high.
- m0_ready  output  1  one-cycle completion pulse to m0.
- m0_rdata  output  DW  read data for m0; valid while m0_ready is high, held afterwards.
- m0_err  output  1  unmapped-address flag; valid with m0_ready.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err: same as m0, for m1.
- A  output  AW  peripheral address (registered).
- WD  output  DW  peripheral write data (registered).
- WE  output  1  peripheral write enable (registered, one-cycle pulse).
- RD  input  DW  peripheral read data; combinational from A.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: A=0, WD=0, WE=0, all ready=0, all rdata=0, all err=0, busy=0, state=IDLE, last_grant=1 (so m0 wins the first tie).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select the winner:
    - Only one req high: that master wins.
    - Both high, RR_EN=1: the master that is not last_grant wins.
    - Both high, RR_EN=0: m0 wins.
  - On the edge: cur<=winner, last_grant<=winner, A<=addr, WD<=wdata, valid<=addr∈{0,4,8,12}, WE<=we & valid. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - The peripheral sees WE, so a write commits on this edge.
  - On the edge: WE<=0; cur_rdata<=(valid & !we) ? RD : 0; cur_err<=!valid; cur_ready<=1. Go to RESP.
  - A and WD hold their values.
- RESP (1 cycle):
  - ready is high for the current master only.
  - On the edge: ready<=0. Go to IDLE.
- Latency: req sampled in IDLE at edge e0 → ready high in the cycle after edge e1 (2 cycles after sampling). Throughput is one transaction per 3 cycles.
- Masters must drop req in the cycle after ready. A req still high in the first IDLE cycle starts a new transaction; with both masters requesting continuously, grants alternate m0, m1, m0, ...
- The non-granted master's ready, err and rdata are untouched; rdata holds its last value.
- Requests changing while in ACCESS or RESP are ignored; only the latched copies are used.
- Reset asserted in any state: next edge forces IDLE with all reset values. A WE pulse already on the bus completes that cycle; no ready is issued for the aborted transaction.
- Unmapped address: WE is never asserted, rdata=0, err=1, same latency as a mapped access.
- Reads never have side effects on the arbiter; RD is sampled only in ACCESS.

Decomposition:
- Package periph_bus_pkg:
  - address localparams ADDR_DIN=0, ADDR_DOUT=4, ADDR_TIMER0=8, ADDR_7SEG=12;
  - address-valid function;
  - state encoding IDLE/ACCESS/RESP;
  - master index constants M0=0, M1=1.
- Sub-module periph_rr_pick: combinational 2-way winner selection from req[1:0], last_grant and RR_EN. Instantiated once.

Test Plan:
- Single read: m0 reads addr 0 with RD=32'h0000_001F → ready one cycle 2 cycles after req, m0_rdata=32'h1F, err=0, WE never high.
- Single write: m1 writes addr 4, wdata=5'h15 → WE high exactly 1 cycle with A=4, WD=32'h15; m1_ready follows one cycle later; m0_ready stays 0.
- Contention: both req from reset, held for 4 transactions → grant order m0, m1, m0, m1; with RR_EN=0 → m0, m0, m0, m0 while m0 keeps requesting.
- Unmapped: m0 writes addr 3 → WE stays 0, m0_err=1, m0_rdata=0, ready at normal latency.
- Reset mid-op: assert reset in the ACCESS cycle of an m1 read → no m1_ready; next cycle all outputs at reset values; a fresh m1 req then completes normally.
- Back-to-back: m0 keeps req high across ready with a new address 8 → second transaction starts in the next IDLE cycle; busy drops for exactly 1 cycle between transactions.
